// File: rtl/hps_ext_pkg.sv
// hps_ext_pkg: command offsets, EXT_BUS bit map and word-count helpers for hps_ext_regs
package hps_ext_pkg;
  typedef enum logic [1:0] {
    OFS_GET_STATUS = 2'd0,
    OFS_SET_CTRL   = 2'd1,
    OFS_GET_CTRL   = 2'd2,
    OFS_GET_INFO   = 2'd3
  } cmd_ofs_e;
  localparam int EXT_DOUT_LSB = 0;
  localparam int EXT_DIN_LSB  = 16;
  localparam int EXT_DOUT_EN  = 32;
  localparam int EXT_STROBE   = 33;
  localparam int EXT_ENABLE   = 34;
  localparam int WCNT_W       = 8;
  function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/hps_ext_ctrl_bank.sv
// hps_ext_ctrl_bank: N_CTRL 16-bit control registers with indexed write, write pulses, bit-0 clear and read mux
// Ports: clk_i/rst_i clock and async reset; we_i/wr_idx_i/wr_data_i write port;
//        clr_i per-register bit-0 clear; rd_idx_i/rd_data_o combinational read;
//        ctrl_o packed registers; wr_o one-cycle write pulses.
module hps_ext_ctrl_bank #(
  parameter int N_CTRL = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [3:0]           wr_idx_i,
  input  logic [15:0]          wr_data_i,
  input  logic [N_CTRL-1:0]    clr_i,
  input  logic [3:0]           rd_idx_i,
  output logic [15:0]          rd_data_o,
  output logic [N_CTRL*16-1:0] ctrl_o,
  output logic [N_CTRL-1:0]    wr_o
);
  logic [N_CTRL*16-1:0] ctrl_q;
  logic [N_CTRL-1:0]    wr_q;
  // An HPS write beats a same-cycle core clear; out-of-range indices match nothing.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      ctrl_q <= '0;
      wr_q   <= '0;
    end else begin
      for (int i = 0; i < N_CTRL; i++) begin
        wr_q[i] <= we_i && wr_idx_i == 4'(i);
        if (we_i && wr_idx_i == 4'(i)) ctrl_q[i*16 +: 16] <= wr_data_i;
        else if (clr_i[i]) ctrl_q[i*16] <= 1'b0;
      end
    end
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < N_CTRL; i++)
      if (rd_idx_i == 4'(i)) rd_data_o = ctrl_q[i*16 +: 16];
  end
  assign ctrl_o = ctrl_q;
  assign wr_o   = wr_q;
endmodule

// File: rtl/hps_ext_regs.sv
// hps_ext_regs: HPS EXT_BUS command endpoint with status snapshot, control bank, rise counter and info word
// Ports: clk_sys/reset clock and async reset; EXT_BUS HPS bus (dout, din, dout_en, strobe, enable);
//        hps_rise counted level; stat_in/stat_snap status words and capture pulse;
//        ctrl_out/ctrl_wr/ctrl_clr control registers, write pulses and bit-0 clears.
module hps_ext_regs
  import hps_ext_pkg::*;
#(
  parameter logic [15:0] CMD_BASE = 16'h00f0,
  parameter int          N_STAT   = 8,
  parameter int          N_CTRL   = 4
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  inout  wire  [35:0]          EXT_BUS,
  input  logic                 hps_rise,
  input  logic [N_STAT*16-1:0] stat_in,
  output logic                 stat_snap,
  output logic [N_CTRL*16-1:0] ctrl_out,
  output logic [N_CTRL-1:0]    ctrl_wr,
  input  logic [N_CTRL-1:0]    ctrl_clr
);
  logic [15:0]          io_din;
  logic                 io_strobe, io_enable;
  logic [15:0]          io_dout_q, rsp_d, stat_rd, ctrl_rd, ofs_in, ofs;
  logic                 dout_en_q, stat_snap_q, rise_d1_q;
  logic [WCNT_W-1:0]    word_cnt_q;
  logic [15:0]          cmd_q;
  logic [3:0]           idx_q, rd_idx;
  logic [7:0]           rise_cnt_q;
  logic [N_STAT*16-1:0] stat_sh_q;
  logic                 in_ok, cmd_ok, first, w1, ctrl_we;
  cmd_ofs_e             op;
  assign io_din    = EXT_BUS[EXT_DIN_LSB +: 16];
  assign io_strobe = EXT_BUS[EXT_STROBE];
  assign io_enable = EXT_BUS[EXT_ENABLE];
  assign EXT_BUS   = {3'bzzz, dout_en_q, 16'hzzzz, io_dout_q};
  assign ofs_in    = io_din - CMD_BASE;
  assign in_ok     = ofs_in < 16'd4;
  assign ofs       = cmd_q - CMD_BASE;
  assign cmd_ok    = ofs < 16'd4;
  assign op        = cmd_ofs_e'(ofs[1:0]);
  assign first     = word_cnt_q == '0;
  assign w1        = word_cnt_q == WCNT_W'(1);
  assign ctrl_we   = io_enable && io_strobe && !first && !w1 && cmd_ok && op == OFS_SET_CTRL;
  // GET_CTRL word 1 reads the index it carries; later words read one past the latched index.
  assign rd_idx    = w1 ? io_din[3:0] : idx_q + 4'd1;
  hps_ext_ctrl_bank #(.N_CTRL(N_CTRL)) u_bank (
    .clk_i    (clk_sys),
    .rst_i    (reset),
    .we_i     (ctrl_we),
    .wr_idx_i (idx_q),
    .wr_data_i(io_din),
    .clr_i    (ctrl_clr),
    .rd_idx_i (rd_idx),
    .rd_data_o(ctrl_rd),
    .ctrl_o   (ctrl_out),
    .wr_o     (ctrl_wr)
  );
  always_comb begin
    stat_rd = '0;
    for (int k = 0; k < N_STAT; k++)
      if (word_cnt_q == WCNT_W'(k + 1)) stat_rd = stat_sh_q[k*16 +: 16];
    rsp_d = !cmd_ok                ? 16'd0 :
            op == OFS_GET_STATUS   ? (w1 ? stat_in[15:0] : stat_rd) :
            op == OFS_GET_CTRL     ? ctrl_rd :
            op == OFS_GET_INFO     ? (w1 ? {8'(N_CTRL), 8'(N_STAT)} :
                                      word_cnt_q == WCNT_W'(2) ? CMD_BASE : 16'd0) :
                                     16'd0;
  end
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      io_dout_q   <= '0;
      dout_en_q   <= 1'b0;
      word_cnt_q  <= '0;
      cmd_q       <= '0;
      idx_q       <= '0;
      stat_sh_q   <= '0;
      stat_snap_q <= 1'b0;
      rise_d1_q   <= 1'b0;
      rise_cnt_q  <= '0;
    end else begin
      stat_snap_q <= 1'b0;
      rise_d1_q   <= hps_rise;
      if (hps_rise != rise_d1_q) rise_cnt_q <= rise_cnt_q + 8'd1;
      if (!io_enable) begin
        io_dout_q  <= '0;
        dout_en_q  <= 1'b0;
        word_cnt_q <= '0;
        cmd_q      <= '0;
        idx_q      <= '0;
      end else if (io_strobe) begin
        word_cnt_q <= sat_inc(word_cnt_q);
        if (first) begin
          cmd_q     <= io_din;
          dout_en_q <= in_ok;
          io_dout_q <= in_ok ? {8'd0, rise_cnt_q} : 16'd0;
        end else begin
          io_dout_q <= rsp_d;
          if (cmd_ok && op == OFS_GET_STATUS && w1) begin
            stat_sh_q   <= stat_in;
            stat_snap_q <= 1'b1;
          end
          if (cmd_ok && (op == OFS_SET_CTRL || op == OFS_GET_CTRL))
            idx_q <= w1 ? io_din[3:0] : idx_q + 4'd1;
        end
      end
    end
  assign stat_snap = stat_snap_q;
endmodule

// File: tb/tb_hps_ext_regs.sv
// tb_hps_ext_regs: directed self-checking bench for hps_ext_regs
module tb_hps_ext_regs;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, stb = 1'b0, rise = 1'b0;
  logic [15:0] din = '0;
  logic [127:0] stat_in;
  logic        snap;
  logic [63:0] ctrl_out;
  logic [3:0]  ctrl_wr, ctrl_clr = '0;
  wire  [35:0] bus;
  int          total = 0, bad = 0, snaps = 0;
  assign bus = {1'bz, en, stb, 1'bz, din, 16'hzzzz};
  always #5 clk = ~clk;
  hps_ext_regs dut (
    .clk_sys (clk),
    .reset   (rst),
    .EXT_BUS (bus),
    .hps_rise(rise),
    .stat_in (stat_in),
    .stat_snap(snap),
    .ctrl_out(ctrl_out),
    .ctrl_wr (ctrl_wr),
    .ctrl_clr(ctrl_clr)
  );
  always @(posedge clk) if (snap) snaps++;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic word(input logic [15:0] d);
    @(negedge clk);
    stb = 1'b1;
    din = d;
    @(negedge clk);
    stb = 1'b0;
  endtask
  task automatic open_tx;
    @(negedge clk);
    en = 1'b1;
  endtask
  task automatic close_tx;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    for (int k = 0; k < 8; k++) stat_in[k*16 +: 16] = 16'h1000 + 16'(k);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    open_tx;
    word(16'h00f2);
    word(16'h0001);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_dout", 64'(bus[15:0]), 64'h0);
    chk("rst_den", 64'(bus[32]), 64'h0);
    chk("rst_ctrl", ctrl_out, 64'h0);
    chk("rst_wr", 64'(ctrl_wr), 64'h0);
    chk("rst_snap", 64'(snap), 64'h0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    snaps = 0;
    open_tx;
    word(16'h00f0);
    chk("st_w0", 64'(bus[15:0]), 64'h0000);
    chk("st_den", 64'(bus[32]), 64'h1);
    word(16'h0000);
    chk("st_w1", 64'(bus[15:0]), 64'h1000);
    chk("st_snap", 64'(snap), 64'h1);
    for (int k = 0; k < 8; k++) stat_in[k*16 +: 16] = 16'hdead;
    for (int k = 2; k <= 8; k++) begin
      word(16'h0000);
      chk($sformatf("st_w%0d", k), 64'(bus[15:0]), 64'h1000 + 64'(k - 1));
    end
    word(16'h0000);
    chk("st_w9", 64'(bus[15:0]), 64'h0);
    chk("st_snaps", 64'(snaps), 64'h1);
    close_tx;
    chk("st_den_off", 64'(bus[32]), 64'h0);
    open_tx;
    word(16'h00f1);
    word(16'h0002);
    word(16'haaaa);
    chk("sc_wr0", 64'(ctrl_wr), 64'h4);
    chk("sc_c2", 64'(ctrl_out[47:32]), 64'haaaa);
    word(16'h5555);
    chk("sc_wr1", 64'(ctrl_wr), 64'h8);
    chk("sc_c3", 64'(ctrl_out[63:48]), 64'h5555);
    word(16'h1234);
    chk("sc_wr2", 64'(ctrl_wr), 64'h0);
    chk("sc_all", ctrl_out, 64'h5555_aaaa_0000_0000);
    close_tx;
    open_tx;
    word(16'h00f2);
    word(16'h0002);
    chk("gc_w1", 64'(bus[15:0]), 64'haaaa);
    word(16'h0000);
    chk("gc_w2", 64'(bus[15:0]), 64'h5555);
    word(16'h0000);
    chk("gc_w3", 64'(bus[15:0]), 64'h0);
    close_tx;
    open_tx;
    word(16'h00ef);
    chk("bad_den", 64'(bus[32]), 64'h0);
    chk("bad_dout", 64'(bus[15:0]), 64'h0);
    word(16'h0002);
    word(16'hffff);
    chk("bad_dout2", 64'(bus[15:0]), 64'h0);
    chk("bad_wr", 64'(ctrl_wr), 64'h0);
    chk("bad_ctrl", ctrl_out, 64'h5555_aaaa_0000_0000);
    close_tx;
    open_tx;
    word(16'h00f4);
    chk("bad4_den", 64'(bus[32]), 64'h0);
    word(16'h0002);
    word(16'hffff);
    chk("bad4_dout", 64'(bus[15:0]), 64'h0);
    chk("bad4_ctrl", ctrl_out, 64'h5555_aaaa_0000_0000);
    close_tx;
    open_tx;
    word(16'h00f1);
    word(16'h0001);
    @(negedge clk);
    stb = 1'b1;
    din = 16'h0001;
    ctrl_clr = 4'b0010;
    @(negedge clk);
    stb = 1'b0;
    chk("clr_win", 64'(ctrl_out[31:16]), 64'h0001);
    chk("clr_wr", 64'(ctrl_wr), 64'h2);
    @(negedge clk);
    ctrl_clr = 4'b0000;
    chk("clr_alone", 64'(ctrl_out[31:16]), 64'h0000);
    close_tx;
    open_tx;
    word(16'h00f3);
    word(16'h0000);
    chk("info_w1", 64'(bus[15:0]), 64'h0408);
    word(16'h0000);
    chk("info_w2", 64'(bus[15:0]), 64'h00f0);
    word(16'h0000);
    chk("info_w3", 64'(bus[15:0]), 64'h0);
    close_tx;
    for (int i = 0; i < 257; i++) begin
      @(negedge clk);
      rise = ~rise;
    end
    @(negedge clk);
    open_tx;
    word(16'h00f2);
    chk("rise_w0", 64'(bus[15:0]), 64'h0001);
    chk("rise_den", 64'(bus[32]), 64'h1);
    close_tx;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
